bios_window_router: RTL and testbench
=====================================

// Module: bios_window_router
// PURPOSE
//  Routes CPU data-bus accesses that hit the BIOS address window to either the on-chip boot ROM
//  (BRAM) or external SDRAM, selected by the bios_enabled flag from the BIOS control register.
//  Sits between the data-bus address decoder (which drives cs) and the ROM/SDRAM ports.
//  Samples bios_enabled per transaction, so a mid-access flag change never splits a transfer.
//  Guards SDRAM accesses with a timeout.
// PARAMETERS
//  ROM_ADDR_WIDTH   12   word-address bits of boot ROM (4K x 16)
//  TIMEOUT_CYCLES   255  max cycles waiting for ram_m_ack before forced completion (1..65535)
// PORTS
//  clk              in   1    system clock; single clock domain
//  reset            in   1    synchronous, active-high reset
//  cs               in   1    address decoder hit: access targets BIOS window
//  bios_enabled     in   1    1 = ROM serves window, 0 = SDRAM serves window
//  data_m_addr      in   19   CPU word address [19:1]
//  data_m_data_in   in   16   CPU write data
//  data_m_data_out  out  16   read data; 0 except in the ack cycle of a read
//  data_m_bytesel   in   2    byte enables
//  data_m_wr_en     in   1    1 = write
//  data_m_access    in   1    CPU request, held until data_m_ack
//  data_m_ack       out  1    one-cycle completion pulse
//  rom_addr         out  ROM_ADDR_WIDTH  ROM word address (data_m_addr[ROM_ADDR_WIDTH:1])
//  rom_rd_en        out  1    one-cycle ROM read strobe
//  rom_data         in   16   ROM output, valid cycle after rom_rd_en
//  ram_m_addr       out  19   SDRAM word address
//  ram_m_data_out   out  16   SDRAM write data
//  ram_m_data_in    in   16   SDRAM read data, valid with ram_m_ack
//  ram_m_bytesel    out  2    SDRAM byte enables
//  ram_m_wr_en      out  1    SDRAM write
//  ram_m_access     out  1    SDRAM request, held until ram_m_ack or timeout
//  ram_m_ack        in   1    SDRAM completion pulse
//  timeout_err      out  1    one-cycle pulse when an SDRAM access times out
// BEHAVIOUR
//  Reset: state IDLE; data_m_ack, data_m_data_out, rom_rd_en, ram_m_access, ram_m_wr_en,
//   timeout_err = 0; ram_m_addr/data/bytesel = 0; timeout counter = 0.
//  States: IDLE, ROM_RD, RAM_WAIT, DONE.
//  IDLE: on cs && data_m_access (cycle N) latch route = bios_enabled, addr, data, bytesel, wr_en.
//   route=ROM, read : cycle N+1 rom_rd_en=1 -> ROM_RD; N+2 data_m_ack=1, data_m_data_out=rom_data.
//   route=ROM, write: ROM read-only; N+1 data_m_ack=1, data_out=0, no ROM strobe -> DONE.
//   route=RAM: N+1 ram_m_access=1 with latched fields -> RAM_WAIT.
//  RAM_WAIT: counter increments each cycle; on ram_m_ack (cycle M) drop ram_m_access at M+1,
//   data_m_ack=1 at M+1, data_out=ram_m_data_in captured at M (reads) else 0 -> DONE.
//   Counter reaching TIMEOUT_CYCLES with no ack: drop ram_m_access, data_m_ack=1,
//   data_out=16'hFFFF (reads) / 0 (writes), timeout_err=1 same cycle -> DONE.
//   ram_m_ack arriving in the same cycle as timeout: treat as normal ack, no timeout_err.
//  DONE: one guard cycle, ignores data_m_access (CPU may still hold it) -> IDLE.
//  Back-to-back: earliest next accept is the cycle after DONE.
//  bios_enabled changes mid-transaction: ignored until next IDLE accept.
//  cs deasserted or access dropped mid-transaction: transaction still completes as latched.
//  Reset mid-operation: next edge -> IDLE, ram_m_access=0; stray ram_m_ack afterwards ignored.
//  data_m_ack never asserts for accesses with cs=0; data_m_data_out=0 when not acking (OR bus).
// STRUCTURE
//  Package bios_router_pkg: state enum (IDLE, ROM_RD, RAM_WAIT, DONE), route enum (ROUTE_ROM,
//   ROUTE_RAM), constant TIMEOUT_READ_DATA = 16'hFFFF.
//  Sub-module bus_timeout_counter (WIDTH, LIMIT; clear, enable -> expired), reused by other
//   bridges. Remainder is one FSM plus request-latch registers.
// TESTING
//  bios_enabled=1, read addr 0x00010, rom_data=16'hEA5B -> rom_rd_en at N+1, ack+0xEA5B at N+2.
//  bios_enabled=1, write 0x1234 -> ack at N+1, no rom_rd_en, no ram_m_access, data_out=0.
//  bios_enabled=0, read, ram_m_ack 3 cycles later with 0xBEEF -> ack+0xBEEF cycle after ram ack.
//  bios_enabled=0, TIMEOUT_CYCLES=8, no ram ack -> ack+0xFFFF and timeout_err after 8 cycles.
//  Toggle bios_enabled 1->0 during ROM read, then reset during RAM_WAIT -> ROM read completes;
//   after reset ram_m_access=0, late ram_m_ack produces no data_m_ack.
//  Access with cs=0 for 20 cycles -> no ack, no ROM/RAM activity, data_out=0.

Source files
------------

// File: rtl/bios_router_pkg.sv
// Shared types and constants for the BIOS window router.
package bios_router_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROM_RD   = 2'd1,
        RAM_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    typedef enum logic {
        ROUTE_ROM = 1'b0,
        ROUTE_RAM = 1'b1
    } route_t;

    // Returned to the CPU when an SDRAM read is abandoned.
    localparam logic [15:0] TIMEOUT_READ_DATA = 16'hFFFF;

endpackage

// File: rtl/bus_timeout_counter.sv
// Bus-wait watchdog: counts enabled cycles and flags the LIMIT-th one.
module bus_timeout_counter #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    // expired is high during the LIMIT-th consecutive enabled cycle.
    assign expired = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bios_window_router.sv
// Steers BIOS-window data accesses to boot ROM or SDRAM, with an SDRAM wait timeout.
module bios_window_router
    import bios_router_pkg::*;
#(
    parameter int ROM_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cs,
    input  logic                      bios_enabled,
    input  logic [19:1]               data_m_addr,
    input  logic [15:0]               data_m_data_in,
    output logic [15:0]               data_m_data_out,
    input  logic [1:0]                data_m_bytesel,
    input  logic                      data_m_wr_en,
    input  logic                      data_m_access,
    output logic                      data_m_ack,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    output logic                      rom_rd_en,
    input  logic [15:0]               rom_data,
    output logic [19:1]               ram_m_addr,
    output logic [15:0]               ram_m_data_out,
    input  logic [15:0]               ram_m_data_in,
    output logic [1:0]                ram_m_bytesel,
    output logic                      ram_m_wr_en,
    output logic                      ram_m_access,
    input  logic                      ram_m_ack,
    output logic                      timeout_err
);

    state_t      state;
    route_t      route_sel;
    logic [19:1] req_addr;
    logic [15:0] req_data;
    logic [1:0]  req_bytesel;
    logic        req_wr;
    logic [15:0] data_q;
    logic        rom_ack;
    logic        wait_active;
    logic        wait_clear;
    logic        expired;

    assign route_sel   = bios_enabled ? ROUTE_ROM : ROUTE_RAM;
    assign wait_active = (state == RAM_WAIT);
    assign wait_clear  = !wait_active;

    bus_timeout_counter #(
        .WIDTH(16),
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_clear),
        .enable (wait_active),
        .expired(expired)
    );

    assign rom_addr       = req_addr[ROM_ADDR_WIDTH:1];
    assign ram_m_addr     = req_addr;
    assign ram_m_data_out = req_data;
    assign ram_m_bytesel  = req_bytesel;
    assign ram_m_wr_en    = ram_m_access && req_wr;

    // ROM data arrives combinationally in the ack cycle; all other sources are registered.
    assign data_m_data_out = rom_ack ? rom_data : data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            data_m_ack   <= 1'b0;
            data_q       <= '0;
            rom_ack      <= 1'b0;
            rom_rd_en    <= 1'b0;
            ram_m_access <= 1'b0;
            timeout_err  <= 1'b0;
            req_addr     <= '0;
            req_data     <= '0;
            req_bytesel  <= '0;
            req_wr       <= 1'b0;
        end else begin
            data_m_ack  <= 1'b0;
            data_q      <= '0;
            rom_ack     <= 1'b0;
            rom_rd_en   <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs && data_m_access) begin
                        req_addr    <= data_m_addr;
                        req_data    <= data_m_data_in;
                        req_bytesel <= data_m_bytesel;
                        req_wr      <= data_m_wr_en;
                        if (route_sel == ROUTE_ROM) begin
                            // Writes into the ROM window are acknowledged and dropped.
                            if (data_m_wr_en) begin
                                data_m_ack <= 1'b1;
                                state      <= DONE;
                            end else begin
                                rom_rd_en <= 1'b1;
                                state     <= ROM_RD;
                            end
                        end else begin
                            ram_m_access <= 1'b1;
                            state        <= RAM_WAIT;
                        end
                    end
                end

                ROM_RD: begin
                    data_m_ack <= 1'b1;
                    rom_ack    <= 1'b1;
                    state      <= DONE;
                end

                RAM_WAIT: begin
                    // A real ack takes priority over a timeout landing in the same cycle.
                    if (ram_m_ack) begin
                        ram_m_access <= 1'b0;
                        data_m_ack   <= 1'b1;
                        data_q       <= req_wr ? 16'h0000 : ram_m_data_in;
                        state        <= DONE;
                    end else if (expired) begin
                        ram_m_access <= 1'b0;
                        data_m_ack   <= 1'b1;
                        data_q       <= req_wr ? 16'h0000 : TIMEOUT_READ_DATA;
                        timeout_err  <= 1'b1;
                        state        <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bios_window_router.sv
// Directed-vector bench for bios_window_router (TIMEOUT_CYCLES = 8).
module tb_bios_window_router;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        bios_enabled;
    logic [19:1] data_m_addr;
    logic [15:0] data_m_data_in;
    logic [15:0] data_m_data_out;
    logic [1:0]  data_m_bytesel;
    logic        data_m_wr_en;
    logic        data_m_access;
    logic        data_m_ack;
    logic [11:0] rom_addr;
    logic        rom_rd_en;
    logic [15:0] rom_data;
    logic [19:1] ram_m_addr;
    logic [15:0] ram_m_data_out;
    logic [15:0] ram_m_data_in;
    logic [1:0]  ram_m_bytesel;
    logic        ram_m_wr_en;
    logic        ram_m_access;
    logic        ram_m_ack;
    logic        timeout_err;

    int checks;
    int errors;

    bios_window_router #(
        .ROM_ADDR_WIDTH(12),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cs             (cs),
        .bios_enabled   (bios_enabled),
        .data_m_addr    (data_m_addr),
        .data_m_data_in (data_m_data_in),
        .data_m_data_out(data_m_data_out),
        .data_m_bytesel (data_m_bytesel),
        .data_m_wr_en   (data_m_wr_en),
        .data_m_access  (data_m_access),
        .data_m_ack     (data_m_ack),
        .rom_addr       (rom_addr),
        .rom_rd_en      (rom_rd_en),
        .rom_data       (rom_data),
        .ram_m_addr     (ram_m_addr),
        .ram_m_data_out (ram_m_data_out),
        .ram_m_data_in  (ram_m_data_in),
        .ram_m_bytesel  (ram_m_bytesel),
        .ram_m_wr_en    (ram_m_wr_en),
        .ram_m_access   (ram_m_access),
        .ram_m_ack      (ram_m_ack),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic bios, input logic wr, input logic [19:1] addr,
                           input logic [15:0] wdata, input logic [1:0] be);
        cs             = 1'b1;
        data_m_access  = 1'b1;
        bios_enabled   = bios;
        data_m_wr_en   = wr;
        data_m_addr    = addr;
        data_m_data_in = wdata;
        data_m_bytesel = be;
    endtask

    task automatic release_bus();
        cs            = 1'b0;
        data_m_access = 1'b0;
        data_m_wr_en  = 1'b0;
    endtask

    initial begin
        int activity;
        int early_ack;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        cs = 1'b0; bios_enabled = 1'b1; data_m_addr = '0; data_m_data_in = '0;
        data_m_bytesel = 2'b11; data_m_wr_en = 1'b0; data_m_access = 1'b0;
        rom_data = 16'hEA5B; ram_m_data_in = 16'h0000; ram_m_ack = 1'b0;

        tick();
        tick();
        check("reset_ack",     32'(data_m_ack),      32'h0);
        check("reset_dout",    32'(data_m_data_out), 32'h0);
        check("reset_rom_rd",  32'(rom_rd_en),       32'h0);
        check("reset_ram_acc", 32'(ram_m_access),    32'h0);
        check("reset_ram_wr",  32'(ram_m_wr_en),     32'h0);
        check("reset_ram_adr", 32'(ram_m_addr),      32'h0);
        check("reset_tmo",     32'(timeout_err),     32'h0);
        reset = 1'b0;
        tick();

        // ROM read
        request(1'b1, 1'b0, 19'h00010, 16'h0000, 2'b11);
        tick();
        check("romrd_strobe",   32'(rom_rd_en),  32'h1);
        check("romrd_addr",     32'(rom_addr),   32'h010);
        check("romrd_noack",    32'(data_m_ack), 32'h0);
        tick();
        check("romrd_ack",      32'(data_m_ack),      32'h1);
        check("romrd_data",     32'(data_m_data_out), 32'hEA5B);
        check("romrd_strobe_off", 32'(rom_rd_en),     32'h0);
        check("romrd_no_ram",   32'(ram_m_access),    32'h0);
        release_bus();
        tick();
        check("romrd_idle_ack",  32'(data_m_ack),      32'h0);
        check("romrd_idle_dout", 32'(data_m_data_out), 32'h0);

        // ROM write, held access across the guard cycle gives back-to-back acks
        request(1'b1, 1'b1, 19'h00020, 16'h1234, 2'b11);
        tick();
        check("romwr_ack",     32'(data_m_ack),      32'h1);
        check("romwr_dout",    32'(data_m_data_out), 32'h0);
        check("romwr_nostrb",  32'(rom_rd_en),       32'h0);
        check("romwr_noram",   32'(ram_m_access),    32'h0);
        tick();
        check("romwr_guard",   32'(data_m_ack),      32'h0);
        tick();
        check("romwr_b2b_ack", 32'(data_m_ack),      32'h1);
        release_bus();
        tick();
        tick();

        // SDRAM read, ack three cycles after the request; flag flip must be ignored
        request(1'b0, 1'b0, 19'h5A5A5, 16'h0000, 2'b10);
        tick();
        check("ramrd_access",  32'(ram_m_access),  32'h1);
        check("ramrd_addr",    32'(ram_m_addr),    32'h5A5A5);
        check("ramrd_be",      32'(ram_m_bytesel), 32'h2);
        check("ramrd_wr",      32'(ram_m_wr_en),   32'h0);
        bios_enabled = 1'b1;
        tick();
        tick();
        ram_m_ack = 1'b1;
        ram_m_data_in = 16'hBEEF;
        #1;
        check("ramrd_wait_dout", 32'(data_m_data_out), 32'h0);
        check("ramrd_wait_ack",  32'(data_m_ack),      32'h0);
        tick();
        ram_m_ack = 1'b0;
        ram_m_data_in = 16'h0000;
        check("ramrd_ack",     32'(data_m_ack),      32'h1);
        check("ramrd_data",    32'(data_m_data_out), 32'hBEEF);
        check("ramrd_drop",    32'(ram_m_access),    32'h0);
        check("ramrd_notmo",   32'(timeout_err),     32'h0);
        release_bus();
        tick();
        check("ramrd_idle_dout", 32'(data_m_data_out), 32'h0);

        // SDRAM write: read-bus data must not leak to the CPU
        request(1'b0, 1'b1, 19'h00333, 16'hC3C3, 2'b01);
        tick();
        check("ramwr_wr",      32'(ram_m_wr_en),    32'h1);
        check("ramwr_data",    32'(ram_m_data_out), 32'hC3C3);
        ram_m_ack = 1'b1;
        ram_m_data_in = 16'hFFFF;
        tick();
        ram_m_ack = 1'b0;
        ram_m_data_in = 16'h0000;
        check("ramwr_ack",     32'(data_m_ack),      32'h1);
        check("ramwr_dout",    32'(data_m_data_out), 32'h0);
        check("ramwr_wr_off",  32'(ram_m_wr_en),     32'h0);
        release_bus();
        tick();

        // SDRAM read timeout after 8 wait cycles
        request(1'b0, 1'b0, 19'h00100, 16'h0000, 2'b11);
        tick();
        early_ack = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (data_m_ack || timeout_err || !ram_m_access) early_ack++;
        end
        check("tmo_no_early", 32'(early_ack), 32'h0);
        tick();
        check("tmo_ack",      32'(data_m_ack),      32'h1);
        check("tmo_data",     32'(data_m_data_out), 32'hFFFF);
        check("tmo_err",      32'(timeout_err),     32'h1);
        check("tmo_drop",     32'(ram_m_access),    32'h0);
        release_bus();
        tick();
        check("tmo_err_pulse", 32'(timeout_err), 32'h0);

        // Ack landing in the timeout cycle wins
        request(1'b0, 1'b0, 19'h00101, 16'h0000, 2'b11);
        for (int i = 0; i < 8; i++) tick();
        ram_m_ack = 1'b1;
        ram_m_data_in = 16'h1357;
        tick();
        ram_m_ack = 1'b0;
        ram_m_data_in = 16'h0000;
        check("race_ack",   32'(data_m_ack),      32'h1);
        check("race_data",  32'(data_m_data_out), 32'h1357);
        check("race_noerr", 32'(timeout_err),     32'h0);
        release_bus();
        tick();

        // Flag drops during a ROM read, then reset lands during an SDRAM wait
        rom_data = 16'h600D;
        request(1'b1, 1'b0, 19'h00444, 16'h0000, 2'b11);
        tick();
        bios_enabled = 1'b0;
        tick();
        check("flip_ack",   32'(data_m_ack),      32'h1);
        check("flip_data",  32'(data_m_data_out), 32'h600D);
        check("flip_noram", 32'(ram_m_access),    32'h0);
        release_bus();
        tick();
        request(1'b0, 1'b0, 19'h00555, 16'h0000, 2'b11);
        tick();
        check("rst_pre_access", 32'(ram_m_access), 32'h1);
        release_bus();
        reset = 1'b1;
        tick();
        check("rst_access", 32'(ram_m_access), 32'h0);
        check("rst_ack",    32'(data_m_ack),   32'h0);
        reset = 1'b0;
        ram_m_ack = 1'b1;
        ram_m_data_in = 16'hBAD0;
        tick();
        ram_m_ack = 1'b0;
        ram_m_data_in = 16'h0000;
        tick();
        check("stray_ack",  32'(data_m_ack),      32'h0);
        check("stray_dout", 32'(data_m_data_out), 32'h0);

        // Decoder miss: requests with cs low must produce nothing
        rom_data = 16'hEA5B;
        cs = 1'b0;
        data_m_access = 1'b1;
        activity = 0;
        for (int i = 0; i < 20; i++) begin
            bios_enabled = i[0];
            data_m_wr_en = i[1];
            tick();
            if (data_m_ack || rom_rd_en || ram_m_access || timeout_err || (data_m_data_out != 16'h0))
                activity++;
        end
        check("cs_low_quiet", 32'(activity), 32'h0);
        release_bus();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
